uart_tx_io: RTL and testbench
=============================

Name: uart_tx_io

Overview:
- Memory-mapped UART transmitter peripheral: the output-direction counterpart of the switch input path.
- The CPU writes bytes through the MemOrIO IO-write path (ioWrite, low two address bits, write_data); the block queues them in an 8-entry FIFO and serializes them 8N1 on tx.
- The CPU polls a status word over the IO-read path.
- Sits beside led/switch in main, selected by a new UartCtrl chip select decoded in MemOrIO.

Parameters:
- CLK_FREQ, 23_000_000, cpuclk output frequency in Hz.
- BAUD, 9600, serial bit rate.
- DIV, CLK_FREQ/BAUD (integer truncation, 2395 at defaults), clock cycles per serial bit; derived, not overridden.
- FIFO_DEPTH, 8, transmit FIFO entries; power of two, minimum 2.

Ports:
- clock  input  1  CPU clock (cpuclk clk_out1); all state on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- UartCtrl  input  1  chip select from MemOrIO.
- ioWrite  input  1  IO write strobe from control32.
- ioRead  input  1  IO read strobe from control32.
- uartAddr  input  2  low two address bits.
- write_data  input  32  CPU store data; only [7:0] used.
- read_data  output  16  status word to MemOrIO io_rdata.
- tx  output  1  serial line; idle high.

Behaviour:
- Reset (reset=0, asynchronous): FIFO empty, count=0, overflow=0, FSM=IDLE, baud counter=0, bit index=0, tx=1. read_data follows its combinational rule.
- Push: wr = UartCtrl & ioWrite & uartAddr==2'b00. Accepted when count<FIFO_DEPTH, or count==FIFO_DEPTH with a pop in the same cycle. Otherwise the byte is dropped and overflow is set to 1 (sticky).
- Clear overflow: UartCtrl & ioWrite & uartAddr==2'b10 sets overflow to 0. A set and a clear in the same cycle are impossible (different addresses).
- Writes to 2'b01 and 2'b11 are ignored.
- Status read: when UartCtrl & ioRead & uartAddr==2'b10, read_data = {8'b0, count[3:0], overflow, busy, full, empty}, combinational, same cycle. At all other times read_data=16'h0000. busy = (FSM != IDLE).
- FIFO: circular buffer with wrapping read/write pointers and a separate count (0..FIFO_DEPTH). Pop and push in the same cycle leave count unchanged. There is no bypass: a byte pushed into an empty FIFO is popped no earlier than the next cycle.
- FSM states: IDLE, START, DATA, STOP. A baud counter counts 0..DIV-1 in every non-IDLE state; "bit end" = counter==DIV-1.
  - IDLE: tx=1. If the FIFO is not empty: pop the head into an 8-bit shift register, clear the counter, go to START.
  - START: tx=0 for DIV cycles. At bit end go to DATA with bit index=0.
  - DATA: tx=shift[0], LSB first. At bit end shift right and increment the index. After index 7 go to STOP.
  - STOP: tx=1 for DIV cycles. At bit end: if the FIFO is not empty, pop and go directly to START (back-to-back frames, no idle gap); else go to IDLE.
- Frame length: exactly 10*DIV cycles. Latency from an accepted push into an empty, idle FIFO to the tx falling edge is 1 cycle (the pop cycle).
- tx is driven from a register, so it is glitch-free.
- Mid-frame reset: tx returns to 1 immediately and all queued bytes are discarded.
- No other register resets asynchronously except through reset.

Decomposition:
- Shared package: UART address offsets (TX_DATA=2'b00, STATUS=2'b10), the FSM state encoding, and the status bit positions.
- One sub-module, uart_tx_fifo (parameterized FIFO_DEPTH, 8-bit width), exposing push, pop, dout, count, full, empty.
- The FSM, baud counter and IO decode stay in uart_tx_io.

Test Plan:
All scenarios use CLK_FREQ=160, BAUD=10 (DIV=16).
- Reset: hold reset=0, release -> tx=1, status read = 16'h0001 (empty), busy=0.
- Single byte: write 8'hA5 to 2'b00 -> tx low 1 cycle later for 16 cycles, then bits 1,0,1,0,0,1,0,1 of 16 cycles each, then stop high. busy=1 during the frame; status returns to 16'h0001 after 160 cycles.
- Back-to-back: write 8'h55 then 8'h0F on consecutive cycles -> two frames with no idle cycle between the first stop bit and the second start bit; total 320 cycles.
- Full/overflow: write 10 bytes while the first frame is in progress -> 9 accepted (1 popped plus 8 queued), 10th dropped. Status = count 8, full=1, overflow=1. Write to 2'b10 -> overflow=0.
- Simultaneous push/pop at full: push exactly at the STOP bit end with count=8 -> byte accepted, count stays 8, overflow stays 0.
- Reset mid-frame: assert reset during DATA bit 3 -> tx=1 asynchronously. After release, status=16'h0001 and no further frames appear.

Source files
------------

// File: rtl/uart_tx_io_pkg.sv
// uart_tx_io_pkg: register offsets, FSM encoding and status bit positions for the UART transmitter
package uart_tx_io_pkg;
  localparam logic [1:0] ADDR_TX_DATA = 2'b00;
  localparam logic [1:0] ADDR_STATUS  = 2'b10;
  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_COUNT = 4;
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular byte FIFO with wrapping pointers and an explicit occupancy count
module uart_tx_fifo
  import uart_tx_io_pkg::*;
#(
  parameter int  FIFO_DEPTH = 8,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] rp_q, rp_d, wp_q, wp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;
  assign empty = cnt_q == '0;
  assign full  = cnt_q == CW'(FIFO_DEPTH);
  assign count = cnt_q;
  assign dout  = mem_q[rp_q];
  // a push into a full FIFO only lands when the head leaves in the same cycle
  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    rp_d    = do_pop ? rp_q + AW'(1) : rp_q;
    wp_d    = do_push ? wp_q + AW'(1) : wp_q;
    cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
  end
  // pointer and count registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rp_q  <= '0;
      wp_q  <= '0;
      cnt_q <= '0;
    end else begin
      rp_q  <= rp_d;
      wp_q  <= wp_d;
      cnt_q <= cnt_d;
    end
  end
  // storage needs no reset: the count decides what is valid
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wp_q] <= din;
  end
endmodule

// File: rtl/uart_tx_io.sv
// uart_tx_io: memory-mapped 8N1 UART transmitter with a byte FIFO and a polled status word
module uart_tx_io
  import uart_tx_io_pkg::*;
#(
  parameter int CLK_FREQ   = 23_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        UartCtrl,
  input  logic        ioWrite,
  input  logic        ioRead,
  input  logic [1:0]  uartAddr,
  input  logic [31:0] write_data,
  output logic [15:0] read_data,
  output logic        tx
);
  localparam int DIV = CLK_FREQ / BAUD;
  localparam int BW  = DIV > 1 ? $clog2(DIV) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  state_e        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          ovf_q, ovf_d;
  logic          wr, clr, rd, push, pop, full, empty, bit_end;
  logic [7:0]    dout;
  logic [CW-1:0] count;
  logic [15:0]   status;
  logic          unused_wdata;
  assign unused_wdata = ^write_data[31:8];
  assign wr      = UartCtrl & ioWrite & (uartAddr == ADDR_TX_DATA);
  assign clr     = UartCtrl & ioWrite & (uartAddr == ADDR_STATUS);
  assign rd      = UartCtrl & ioRead & (uartAddr == ADDR_STATUS);
  assign push    = wr & (~full | pop);
  assign bit_end = baud_q == BW'(DIV - 1);
  assign tx      = tx_q;
  uart_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (write_data[7:0]),
    .dout  (dout),
    .count (count),
    .full  (full),
    .empty (empty)
  );
  // frame sequencer; tx is registered from the next state so the line never glitches
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop     = 1'b0;
    baud_d  = (state_q == S_IDLE || bit_end) ? '0 : baud_q + BW'(1);
    unique case (state_q)
      S_IDLE: if (!empty) begin
        pop     = 1'b1;
        shift_d = dout;
        state_d = S_START;
      end
      S_START: if (bit_end) begin
        idx_d   = 3'd0;
        state_d = S_DATA;
      end
      S_DATA: if (bit_end) begin
        shift_d = {1'b0, shift_q[7:1]};
        idx_d   = idx_q + 3'd1;
        state_d = idx_q == 3'd7 ? S_STOP : S_DATA;
      end
      S_STOP: if (bit_end) begin
        pop     = ~empty;
        shift_d = empty ? shift_q : dout;
        state_d = empty ? S_IDLE : S_START;
      end
    endcase
    tx_d = state_d == S_START ? 1'b0 : state_d == S_DATA ? shift_d[0] : 1'b1;
  end
  // overflow is sticky until software writes the status offset
  always_comb begin
    ovf_d = clr ? 1'b0 : (wr & ~push) ? 1'b1 : ovf_q;
  end
  // status word is only driven during a status read, otherwise zero
  always_comb begin
    status                = '0;
    status[ST_EMPTY]      = empty;
    status[ST_FULL]       = full;
    status[ST_BUSY]       = state_q != S_IDLE;
    status[ST_OVF]        = ovf_q;
    status[ST_COUNT +: 4] = 4'(count);
    read_data             = rd ? status : 16'h0000;
  end
  // sequencer and flag registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_io.sv
// tb_uart_tx_io: directed checks of the UART transmitter at DIV=16
module tb_uart_tx_io;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        UartCtrl = 1'b0;
  logic        ioWrite = 1'b0;
  logic        ioRead = 1'b0;
  logic [1:0]  uartAddr = 2'b00;
  logic [31:0] write_data = '0;
  logic [15:0] read_data;
  logic        tx;
  int          vec_cnt = 0;
  int          err_cnt = 0;
  typedef struct {
    logic        cs, wr, rd;
    logic [1:0]  addr;
    logic [31:0] data;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[11];
  uart_tx_io #(.CLK_FREQ(160), .BAUD(10), .FIFO_DEPTH(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .UartCtrl   (UartCtrl),
    .ioWrite    (ioWrite),
    .ioRead     (ioRead),
    .uartAddr   (uartAddr),
    .write_data (write_data),
    .read_data  (read_data),
    .tx         (tx)
  );
  always #5 clock = ~clock;
  function automatic logic [15:0] st(input int c, input logic busy, input logic ovf);
    logic [3:0] c4;
    c4 = 4'(c);
    return {8'h00, c4, ovf, busy, c == 8, c == 0};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
    UartCtrl   = 1'b1;
    ioWrite    = 1'b1;
    uartAddr   = a;
    write_data = {24'hABCDEF, d};
    @(posedge clock);
    #1;
    UartCtrl   = 1'b0;
    ioWrite    = 1'b0;
    uartAddr   = 2'b00;
    write_data = '0;
  endtask
  task automatic rd_status(input string name, input logic [15:0] exp);
    UartCtrl = 1'b1;
    ioRead   = 1'b1;
    uartAddr = 2'b10;
    #1;
    chk(name, 32'(read_data), 32'(exp));
    UartCtrl = 1'b0;
    ioRead   = 1'b0;
    uartAddr = 2'b00;
  endtask
  task automatic expect_frame(input logic [7:0] b, input logic [15:0] mid);
    logic e;
    for (int i = 0; i < 160; i++) begin
      @(negedge clock);
      e = i < 16 ? 1'b0 : i < 144 ? b[(i - 16) / 16] : 1'b1;
      chk($sformatf("tx frame %h sample %0d", b, i), 32'(tx), 32'(e));
      if (i == 80) rd_status($sformatf("mid-frame status %h", b), mid);
    end
  endtask
  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 2'b10, 32'h0, 16'h0001};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 2'b10, 32'h0, 16'h0000};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 2'b10, 32'h0, 16'h0000};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 2'b00, 32'h0, 16'h0000};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 2'b01, 32'h0, 16'h0000};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 2'b11, 32'h0, 16'h0000};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 2'b01, 32'hFFFFFF5A, 16'h0000};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 2'b11, 32'h000000C3, 16'h0000};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 2'b00, 32'h00000077, 16'h0000};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 2'b10, 32'h0, 16'h0001};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 2'b10, 32'h0, 16'h0001};
    repeat (3) @(negedge clock);
    chk("tx held in reset", 32'(tx), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    chk("tx after reset", 32'(tx), 32'd1);
    rd_status("status after reset", 16'h0001);
    for (int i = 0; i < 11; i++) begin
      @(negedge clock);
      UartCtrl   = vecs[i].cs;
      ioWrite    = vecs[i].wr;
      ioRead     = vecs[i].rd;
      uartAddr   = vecs[i].addr;
      write_data = vecs[i].data;
      #1;
      chk($sformatf("decode vector %0d", i), 32'(read_data), 32'(vecs[i].exp));
      @(posedge clock);
      #1;
      UartCtrl = 1'b0;
      ioWrite  = 1'b0;
      ioRead   = 1'b0;
      uartAddr = 2'b00;
      write_data = '0;
    end
    repeat (2) @(negedge clock);
    chk("tx idle after ignored writes", 32'(tx), 32'd1);
    rd_status("status after ignored writes", 16'h0001);
    wr_reg(2'b00, 8'hA5);
    @(negedge clock);
    chk("tx one cycle after push", 32'(tx), 32'd1);
    rd_status("status queued before pop", st(1, 1'b0, 1'b0));
    expect_frame(8'hA5, st(0, 1'b1, 1'b0));
    @(negedge clock);
    chk("tx idle after A5", 32'(tx), 32'd1);
    rd_status("status after A5", 16'h0001);
    wr_reg(2'b00, 8'h55);
    wr_reg(2'b00, 8'h0F);
    expect_frame(8'h55, st(1, 1'b1, 1'b0));
    expect_frame(8'h0F, st(0, 1'b1, 1'b0));
    @(negedge clock);
    chk("tx idle after back-to-back", 32'(tx), 32'd1);
    rd_status("status after back-to-back", 16'h0001);
    for (int k = 0; k < 10; k++) wr_reg(2'b00, 8'h30 + 8'(k));
    @(negedge clock);
    rd_status("status full with overflow", st(8, 1'b1, 1'b1));
    wr_reg(2'b10, 8'h00);
    @(negedge clock);
    rd_status("status overflow cleared", st(8, 1'b1, 1'b0));
    repeat (150) @(posedge clock);
    #1;
    chk("tx in stop before simultaneous push", 32'(tx), 32'd1);
    rd_status("status before simultaneous push", st(8, 1'b1, 1'b0));
    wr_reg(2'b00, 8'hC7);
    for (int j = 0; j < 9; j++)
      expect_frame(j < 8 ? 8'h31 + 8'(j) : 8'hC7, st(8 - j, 1'b1, 1'b0));
    @(negedge clock);
    chk("tx idle after drain", 32'(tx), 32'd1);
    rd_status("status after drain", 16'h0001);
    wr_reg(2'b00, 8'h00);
    wr_reg(2'b00, 8'hAA);
    repeat (69) @(posedge clock);
    #3;
    chk("tx low in data bit 3", 32'(tx), 32'd0);
    reset = 1'b0;
    #1;
    chk("tx high on async reset", 32'(tx), 32'd1);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    rd_status("status after mid-frame reset", 16'h0001);
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      chk($sformatf("tx quiet after reset %0d", i), 32'(tx), 32'd1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
